// File: rtl/fifo.sv
// Packet-aware synchronous FIFO: each entry carries {sop, eop, data}, with a
// registered one-cycle read port, overflow pulse on dropped writes and async active-low reset.
module fifo #(
    parameter int fifo_data_width      = 16,
    parameter int fifo_num_of_priority = 8,
    parameter int fifo_length          = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       next_data,
    input  logic                       wr_sop,
    input  logic                       wr_eop,
    input  logic                       wr_vld,
    input  logic [fifo_data_width-1:0] wr_data,
    output logic                       ready,
    output logic                       overflow,
    output logic                       sop,
    output logic                       eop,
    output logic                       vld,
    output logic [fifo_data_width-1:0] out_data
);
    localparam int PW = $clog2(fifo_length);
    localparam int CW = $clog2(fifo_length + 1);
    localparam int EW = fifo_data_width + 2;

    // The priority count is reserved; only sanity-checked here.
    if (fifo_length < 2 || (fifo_length & (fifo_length - 1)) != 0 || fifo_num_of_priority < 1) begin : g_bad_params
        $error("fifo: fifo_length must be a power of two >= 2");
    end

    logic [EW-1:0]              mem [fifo_length];
    logic [PW-1:0]              wr_ptr_reg;
    logic [PW-1:0]              rd_ptr_reg;
    logic [CW-1:0]              count_reg;
    logic                       pend_sop_reg;
    logic                       overflow_reg;
    logic                       vld_reg;
    logic                       sop_reg;
    logic                       eop_reg;
    logic [fifo_data_width-1:0] data_reg;

    logic full;
    logic do_pop;
    logic do_wr;

    assign full   = (count_reg == CW'(fifo_length));
    assign do_pop = next_data && (count_reg != '0);
    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign do_wr  = wr_vld && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_reg] <= {wr_sop | pend_sop_reg, wr_eop, wr_data};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pend_sop_reg <= 1'b0;
            overflow_reg <= 1'b0;
            vld_reg      <= 1'b0;
            sop_reg      <= 1'b0;
            eop_reg      <= 1'b0;
            data_reg     <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            case ({do_wr, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
            if (do_wr) begin
                pend_sop_reg <= 1'b0;
            end else if (wr_sop && !wr_vld) begin
                pend_sop_reg <= 1'b1;
            end
            overflow_reg <= wr_vld && full && !do_pop;
            vld_reg      <= do_pop;
            if (do_pop) begin
                {sop_reg, eop_reg, data_reg} <= mem[rd_ptr_reg];
            end else begin
                sop_reg <= 1'b0;
                eop_reg <= 1'b0;
            end
        end
    end

    assign ready    = (count_reg != '0);
    assign overflow = overflow_reg;
    assign vld      = vld_reg;
    assign sop      = sop_reg;
    assign eop      = eop_reg;
    assign out_data = data_reg;
endmodule

// File: tb/tb_fifo.sv
// Self-checking bench for fifo: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          next_data = 1'b0;
    logic          wr_sop = 1'b0;
    logic          wr_eop = 1'b0;
    logic          wr_vld = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          ready;
    logic          overflow;
    logic          sop;
    logic          eop;
    logic          vld;
    logic [DW-1:0] out_data;

    int passed = 0;
    int total  = 0;
    bit cmp_en = 1'b0;

    fifo #(.fifo_data_width(DW), .fifo_num_of_priority(8), .fifo_length(DEPTH)) dut (
        .clk(clk), .rst(rst), .next_data(next_data), .wr_sop(wr_sop), .wr_eop(wr_eop),
        .wr_vld(wr_vld), .wr_data(wr_data), .ready(ready), .overflow(overflow),
        .sop(sop), .eop(eop), .vld(vld), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Reference model: a queue of {sop, eop, data} entries.
    typedef struct packed {
        logic          s;
        logic          e;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          q[$];
    bit            m_pend = 1'b0;
    bit            m_vld = 1'b0;
    bit            m_sop = 1'b0;
    bit            m_eop = 1'b0;
    bit            m_ovf = 1'b0;
    logic [DW-1:0] m_data = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q.delete();
            m_pend = 1'b0; m_vld = 1'b0; m_sop = 1'b0; m_eop = 1'b0; m_ovf = 1'b0; m_data = '0;
        end else begin
            int  n;
            bit  pop, wr;
            ent_t e;
            n   = q.size();
            pop = next_data && n > 0;
            wr  = wr_vld && (n < DEPTH || pop);
            m_ovf = wr_vld && n == DEPTH && !pop;
            if (pop) begin
                e = q.pop_front();
                m_vld = 1'b1; m_sop = e.s; m_eop = e.e; m_data = e.d;
            end else begin
                m_vld = 1'b0; m_sop = 1'b0; m_eop = 1'b0;
            end
            if (wr) begin
                q.push_back('{s: wr_sop | m_pend, e: wr_eop, d: wr_data});
                m_pend = 1'b0;
            end else if (wr_sop && !wr_vld) begin
                m_pend = 1'b1;
            end
        end
    end

    int vld_seen = 0, sop_seen = 0, eop_seen = 0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready",    ready,    q.size() > 0);
            chk("overflow", overflow, m_ovf);
            chk("vld",      vld,      m_vld);
            chk("sop",      sop,      m_sop);
            chk("eop",      eop,      m_eop);
            chk("out_data", out_data, m_data);
            vld_seen += vld;
            sop_seen += sop;
            eop_seen += eop;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_vld = 0; wr_sop = 0; wr_eop = 0; next_data = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] d;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        cmp_en = 1'b1;
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_vld", vld, 0);
        chk("reset_out", out_data, 0);

        // Fill: sop pulse alone, then D0..D31 with eop on D31.
        cyc();
        wr_sop = 1; cyc(); wr_sop = 0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_vld = 1; wr_data = 16'hA000 + 16'(i); wr_eop = (i == DEPTH - 1);
            cyc();
            if (i == 0) chk("ready_first_write", ready, 1);
        end
        idle();
        chk("full_ready", ready, 1);
        chk("model_full", q.size(), 32);

        // 33rd write with no read is dropped.
        wr_vld = 1; wr_data = 16'hDEAD; cyc(); idle();
        chk("ovf_pulse", overflow, 1);
        cyc();
        chk("ovf_one_cycle", overflow, 0);

        next_data = 1;
        for (int i = 0; i < DEPTH; i++) begin
            cyc();
            chk("rd_data", out_data, 16'hA000 + 16'(i));
            chk("rd_sop", sop, i == 0);
            chk("rd_eop", eop, i == DEPTH - 1);
        end
        idle();
        chk("empty_after_read", ready, 0);
        cyc();

        // Refill with sop and vld together, then simultaneous write+read while full.
        for (int i = 0; i < DEPTH; i++) begin
            wr_vld = 1; wr_sop = (i == 0); wr_data = 16'hA000 + 16'(i); wr_eop = 0;
            cyc();
        end
        wr_sop = 0;
        wr_vld = 1; wr_data = 16'hBEEF; next_data = 1;
        cyc();
        wr_vld = 0;
        chk("full_rw_ovf", overflow, 0);
        chk("full_rw_data", out_data, 16'hA000);
        chk("full_rw_sop", sop, 1);
        chk("full_rw_count", q.size(), 32);
        for (int i = 1; i <= DEPTH; i++) begin
            cyc();
            if (i == DEPTH) chk("full_rw_last", out_data, 16'hBEEF);
        end
        idle();
        cyc();

        // Read request on empty FIFO, and write+read into empty (no bypass).
        next_data = 1; cyc();
        chk("empty_rd_vld", vld, 0);
        wr_vld = 1; wr_data = 16'h7777; cyc(); wr_vld = 0;
        chk("no_bypass_vld", vld, 0);
        chk("no_bypass_ready", ready, 1);
        cyc();
        chk("after_bypass_vld", vld, 1);
        chk("after_bypass_data", out_data, 16'h7777);
        idle(); cyc();

        // Reset mid-packet while a read is being presented.
        wr_vld = 1; wr_sop = 1; wr_data = 16'h1111; cyc();
        wr_sop = 0; wr_data = 16'h2222; cyc();
        wr_vld = 0; next_data = 1; cyc();
        idle();
        rst = 1'b0; #1;
        chk("rst_vld", vld, 0);
        chk("rst_ready", ready, 0);
        chk("rst_out", out_data, 0);
        chk("rst_sop", sop, 0);
        #2 rst = 1'b1;
        cyc();

        // 20 packets of 3 words with concurrent reads, crossing pointer wrap.
        vld_seen = 0; sop_seen = 0; eop_seen = 0;
        for (int p = 0; p < 20; p++) begin
            for (int w = 0; w < 3; w++) begin
                wr_vld = 1; wr_sop = (w == 0); wr_eop = (w == 2);
                wr_data = 16'h5000 + 16'(p * 3 + w);
                next_data = (p * 3 + w) >= 4;
                cyc();
            end
        end
        wr_vld = 0; wr_sop = 0; wr_eop = 0; next_data = 1;
        for (int k = 0; k < 40 && (q.size() > 0 || vld); k++) cyc();
        idle(); cyc();
        chk("pkt_vld_count", vld_seen, 60);
        chk("pkt_sop_count", sop_seen, 20);
        chk("pkt_eop_count", eop_seen, 20);
        chk("pkt_last_data", out_data, 16'h503B);
        chk("pkt_drained", ready, 0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
